// File: rtl/flip_pkg.sv
// Shared types for the rectangle-flip controller.
//   ROWS_DEF/COLS_DEF/DEPTH_DEF : default matrix and command-queue geometry
//   coord_t                     : 2-bit row/column coordinate
//   cmd_t                       : queued flip command {r1, r2, c1, c2, last}
//   state_t                     : controller sequencing states
package flip_pkg;

   localparam int unsigned ROWS_DEF  = 4;
   localparam int unsigned COLS_DEF  = 4;
   localparam int unsigned DEPTH_DEF = 4;
   localparam int unsigned COORD_W   = 2;

   typedef logic [COORD_W-1:0] coord_t;

   typedef struct packed {
      coord_t r1;
      coord_t r2;
      coord_t c1;
      coord_t c2;
      logic   last;
   } cmd_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/flip_ctrl_rect_flip_mask.sv
// Combinational corner mask for one flip command.
//   r1, r2, c1, c2 : rectangle corner coordinates
//   mask           : one bit per corner cell, bit index = c*ROWS + r
//   degenerate     : rectangle collapses to a line or point (no flip applied)
module rect_flip_mask
   import flip_pkg::*;
#(
   parameter int unsigned ROWS = ROWS_DEF,
   parameter int unsigned COLS = COLS_DEF
) (
   input  coord_t                 r1,
   input  coord_t                 r2,
   input  coord_t                 c1,
   input  coord_t                 c2,
   output logic [ROWS*COLS-1:0]   mask,
   output logic                   degenerate
);

   logic [ROWS-1:0] row_hit;
   logic [COLS-1:0] col_hit;

   // A cell is a corner exactly when its row is r1/r2 and its column is c1/c2.
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign row_hit[r] = (32'(r1) == 32'(r)) || (32'(r2) == 32'(r));
   end

   for (genvar c = 0; c < COLS; c++) begin : g_col
      assign col_hit[c] = (32'(c1) == 32'(c)) || (32'(c2) == 32'(c));
   end

   for (genvar c = 0; c < COLS; c++) begin : g_mc
      for (genvar r = 0; r < ROWS; r++) begin : g_mr
         assign mask[c*ROWS + r] = row_hit[r] & col_hit[c];
      end
   end

   assign degenerate = (r1 == r2) || (c1 == c2);

endmodule

// File: rtl/flip_ctrl.sv
// Rectangle-flip controller: loads a bit matrix, then applies queued
// corner-flip commands one per cycle until the command marked last.
//   clk, rst            : clock, asynchronous active-high reset
//   load_valid/ready    : initial matrix handshake (ready only in IDLE)
//   load_data           : initial matrix, bit index = c*ROWS + r
//   cmd_valid/ready     : command push handshake into the FIFO
//   cmd_r1..cmd_c2      : rectangle coordinates; cmd_last ends the sequence
//   hold                : stalls FIFO pops while high
//   m_out               : current matrix
//   busy, done          : RUN indicator, one-cycle end-of-sequence pulse
//   flip_count          : applied commands (saturating)
//   skip_count          : degenerate commands skipped (saturating)
module flip_ctrl
   import flip_pkg::*;
#(
   parameter int unsigned ROWS  = ROWS_DEF,
   parameter int unsigned COLS  = COLS_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_valid,
   input  logic [ROWS*COLS-1:0] load_data,
   output logic                 load_ready,
   input  logic                 cmd_valid,
   input  coord_t               cmd_r1,
   input  coord_t               cmd_r2,
   input  coord_t               cmd_c1,
   input  coord_t               cmd_c2,
   input  logic                 cmd_last,
   output logic                 cmd_ready,
   input  logic                 hold,
   output logic [ROWS*COLS-1:0] m_out,
   output logic                 busy,
   output logic                 done,
   output logic [7:0]           flip_count,
   output logic [7:0]           skip_count
);

   localparam int unsigned N     = ROWS * COLS;
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   state_t             state;
   state_t             state_nxt;
   cmd_t               mem [DEPTH];
   cmd_t               in_cmd;
   cmd_t               head;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   count_nxt;
   logic               push;
   logic               pop;
   logic               load_hs;
   logic               ready_nxt;
   logic [N-1:0]       mask;
   logic               degen;

   assign in_cmd = '{r1: cmd_r1, r2: cmd_r2, c1: cmd_c1, c2: cmd_c2, last: cmd_last};
   assign head   = mem[rd_ptr];
   assign push   = cmd_valid && cmd_ready;

   rect_flip_mask #(.ROWS(ROWS), .COLS(COLS)) u_mask (
      .r1         (head.r1),
      .r2         (head.r2),
      .c1         (head.c1),
      .c2         (head.c2),
      .mask       (mask),
      .degenerate (degen)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state, load/pop strobes and next FIFO occupancy.
   always_comb begin
      state_nxt = state;
      load_hs   = 1'b0;
      pop       = 1'b0;
      count_nxt = count;
      unique case (state)
         IDLE: begin
            if (load_valid && load_ready) begin
               load_hs   = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if ((count != '0) && !hold) begin
               pop = 1'b1;
               if (head.last) state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      unique case ({push, pop})
         2'b10:   count_nxt = count + CNT_W'(1);
         2'b01:   count_nxt = count - CNT_W'(1);
         default: count_nxt = count;
      endcase
      // Leftover commands are flushed on the way back to IDLE.
      if (state == DONE) count_nxt = '0;

      ready_nxt = (state_nxt != DONE) && (count_nxt != CNT_W'(DEPTH));
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         count <= count_nxt;
         if (state == DONE) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         end
      end
   end

   // FIFO storage.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_cmd;
   end

   // Status outputs, registered from the next-state decode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         load_ready <= 1'b1;
         cmd_ready  <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         load_ready <= (state_nxt == IDLE);
         cmd_ready  <= ready_nxt;
         busy       <= (state_nxt == RUN);
         done       <= (state_nxt == DONE);
      end
   end

   // Matrix and saturating counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_out      <= '0;
         flip_count <= '0;
         skip_count <= '0;
      end else if (load_hs) begin
         m_out      <= load_data;
         flip_count <= '0;
         skip_count <= '0;
      end else if (pop) begin
         if (degen) begin
            if (skip_count != 8'hFF) skip_count <= skip_count + 8'd1;
         end else begin
            m_out <= m_out ^ mask;
            if (flip_count != 8'hFF) flip_count <= flip_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_flip_ctrl.sv
// Self-checking bench for flip_ctrl: queue-based reference model, per-cycle
// output compare, directed scenarios with literal expectations, random runs.
module tb_flip_ctrl;
   import flip_pkg::*;

   localparam int unsigned ROWS  = 4;
   localparam int unsigned COLS  = 4;
   localparam int unsigned DEPTH = 4;
   localparam int PH_IDLE = 0;
   localparam int PH_RUN  = 1;
   localparam int PH_DONE = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_valid = 1'b0;
   logic [15:0] load_data = '0;
   logic        load_ready;
   logic        cmd_valid = 1'b0;
   logic [1:0]  cmd_r1 = '0, cmd_r2 = '0, cmd_c1 = '0, cmd_c2 = '0;
   logic        cmd_last = 1'b0;
   logic        cmd_ready;
   logic        hold = 1'b0;
   logic [15:0] m_out;
   logic        busy, done;
   logic [7:0]  flip_count, skip_count;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   flip_ctrl #(.ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
      .cmd_valid(cmd_valid), .cmd_r1(cmd_r1), .cmd_r2(cmd_r2),
      .cmd_c1(cmd_c1), .cmd_c2(cmd_c2), .cmd_last(cmd_last), .cmd_ready(cmd_ready),
      .hold(hold), .m_out(m_out), .busy(busy), .done(done),
      .flip_count(flip_count), .skip_count(skip_count)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   cmd_t        mq[$];
   logic [15:0] mmat = '0;
   int          mfc = 0;
   int          msc = 0;
   int          mph = PH_IDLE;
   cmd_t        mhd;
   cmd_t        mnew;
   bit          mrdy;
   bit          mpop;

   function automatic logic [15:0] corner(input int r, input int c);
      corner = 16'(1) << (c * 4 + r);
   endfunction

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         mq.delete();
         mmat = '0;
         mfc  = 0;
         msc  = 0;
         mph  = PH_IDLE;
      end else begin
         mrdy = (mph != PH_DONE) && (mq.size() < DEPTH);
         mpop = (mph == PH_RUN) && (mq.size() > 0) && !hold;
         if (mpop) mhd = mq.pop_front();
         if (cmd_valid && mrdy) begin
            mnew.r1 = cmd_r1; mnew.r2 = cmd_r2;
            mnew.c1 = cmd_c1; mnew.c2 = cmd_c2;
            mnew.last = cmd_last;
            mq.push_back(mnew);
         end
         if (mph == PH_IDLE) begin
            if (load_valid) begin
               mmat = load_data; mfc = 0; msc = 0; mph = PH_RUN;
            end
         end else if (mph == PH_RUN) begin
            if (mpop) begin
               if (mhd.r1 == mhd.r2 || mhd.c1 == mhd.c2) begin
                  if (msc < 255) msc = msc + 1;
               end else begin
                  mmat = mmat ^ (corner(int'(mhd.r1), int'(mhd.c1)) | corner(int'(mhd.r1), int'(mhd.c2))
                               | corner(int'(mhd.r2), int'(mhd.c1)) | corner(int'(mhd.r2), int'(mhd.c2)));
                  if (mfc < 255) mfc = mfc + 1;
               end
               if (mhd.last) mph = PH_DONE;
            end
         end else begin
            mph = PH_IDLE;
            mq.delete();
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("m_out",      32'(m_out),      32'(mmat));
         check("flip_count", 32'(flip_count), 32'(mfc));
         check("skip_count", 32'(skip_count), 32'(msc));
         check("busy",       32'(busy),       32'(mph == PH_RUN));
         check("done",       32'(done),       32'(mph == PH_DONE));
         check("load_ready", 32'(load_ready), 32'(mph == PH_IDLE));
         check("cmd_ready",  32'(cmd_ready),  32'((mph != PH_DONE) && (mq.size() < DEPTH)));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_idle();
      int n = 0;
      while (!load_ready && n < 100) begin @(negedge clk); n++; end
      check("wait_idle", 32'(load_ready), 32'd1);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 100) begin @(negedge clk); n++; end
      check("wait_done", 32'(done), 32'd1);
   endtask

   task automatic load(input logic [15:0] d);
      wait_idle();
      load_data  = d;
      load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
   endtask

   task automatic send(input logic [1:0] r1, input logic [1:0] r2, input logic [1:0] c1,
                       input logic [1:0] c2, input logic last, input bit noise);
      int n = 0;
      bit acc = 1'b0;
      cmd_r1 = r1; cmd_r2 = r2; cmd_c1 = c1; cmd_c2 = c2;
      cmd_last = last; cmd_valid = 1'b1;
      while (!acc && n < 200) begin
         if (noise) begin
            hold       = ($urandom_range(0, 3) == 0);
            load_valid = ($urandom_range(0, 7) == 0);
            load_data  = 16'($urandom);
         end
         acc = cmd_ready;
         @(negedge clk);
         n++;
      end
      cmd_valid  = 1'b0;
      cmd_last   = 1'b0;
      load_valid = 1'b0;
      if (!acc) begin
         checks++; errors++;
         $display("FAIL send_timeout: got not-accepted expected accepted at %0t", $time);
      end
   endtask

   // ---------------- scenarios ----------------
   initial begin
      logic [1:0] a, b, c, d;
      repeat (2) @(negedge clk);
      check("rst_m_out", 32'(m_out), 32'h0);
      check("rst_busy",  32'(busy),  32'h0);
      check("rst_done",  32'(done),  32'h0);
      check("rst_flip",  32'(flip_count), 32'h0);
      check("rst_skip",  32'(skip_count), 32'h0);
      check("rst_load_ready", 32'(load_ready), 32'h1);
      rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);

      // single 2x2 flip
      load(16'h0000);
      send(2'd0, 2'd1, 2'd0, 2'd1, 1'b1, 1'b0);
      wait_done();
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'h0);
      check("back_to_idle", 32'(load_ready), 32'h1);
      check("s1_m_out", 32'(m_out), 32'h0033);
      check("s1_flip", 32'(flip_count), 32'd1);

      // same flip twice cancels
      load(16'h0000);
      send(2'd0, 2'd1, 2'd0, 2'd1, 1'b0, 1'b0);
      send(2'd0, 2'd1, 2'd0, 2'd1, 1'b1, 1'b0);
      wait_done(); wait_idle();
      check("s2_m_out", 32'(m_out), 32'h0000);
      check("s2_flip", 32'(flip_count), 32'd2);

      // degenerate command is skipped
      load(16'hFFFF);
      send(2'd2, 2'd2, 2'd0, 2'd3, 1'b1, 1'b0);
      wait_done(); wait_idle();
      check("s3_m_out", 32'(m_out), 32'hFFFF);
      check("s3_skip", 32'(skip_count), 32'd1);
      check("s3_flip", 32'(flip_count), 32'd0);

      // fill FIFO under hold, refuse a fifth, drain on consecutive edges
      load(16'h0000);
      hold = 1'b1;
      send(2'd0, 2'd1, 2'd0, 2'd1, 1'b0, 1'b0);
      send(2'd2, 2'd3, 2'd2, 2'd3, 1'b0, 1'b0);
      send(2'd0, 2'd3, 2'd0, 2'd3, 1'b0, 1'b0);
      send(2'd1, 2'd2, 2'd1, 2'd2, 1'b0, 1'b0);
      check("full_ready", 32'(cmd_ready), 32'h0);
      cmd_r1 = 2'd0; cmd_r2 = 2'd1; cmd_c1 = 2'd0; cmd_c2 = 2'd1;
      cmd_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("fifth_refused", 32'(cmd_ready), 32'h0);
      end
      cmd_valid = 1'b0;
      hold = 1'b0;
      repeat (4) @(negedge clk);
      check("drain_flip", 32'(flip_count), 32'd4);
      check("drain_m_out", 32'(m_out), 32'h5A5A);
      check("drain_ready", 32'(cmd_ready), 32'h1);
      send(2'd0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0);
      wait_done(); wait_idle();
      check("s4_m_out", 32'(m_out), 32'h5A5A);
      check("s4_skip", 32'(skip_count), 32'd1);

      // reset mid-RUN with queued commands
      load(16'hAAAA);
      hold = 1'b1;
      send(2'd0, 2'd1, 2'd0, 2'd1, 1'b0, 1'b0);
      send(2'd2, 2'd3, 2'd2, 2'd3, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("arst_m_out", 32'(m_out), 32'h0);
      check("arst_busy",  32'(busy),  32'h0);
      check("arst_done",  32'(done),  32'h0);
      check("arst_flip",  32'(flip_count), 32'h0);
      check("arst_skip",  32'(skip_count), 32'h0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      hold = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 32'(load_ready), 32'h1);
      load(16'h0000);
      send(2'd1, 2'd2, 2'd1, 2'd2, 1'b1, 1'b0);
      wait_done(); wait_idle();
      check("s5_m_out", 32'(m_out), 32'h0660);

      // counter saturation
      load(16'h0000);
      for (int i = 0; i < 301; i++) begin
         a = 2'($urandom_range(0, 3)); b = a ^ 2'($urandom_range(1, 3));
         c = 2'($urandom_range(0, 3)); d = c ^ 2'($urandom_range(1, 3));
         send(a, b, c, d, (i == 300), 1'b0);
      end
      wait_done(); wait_idle();
      check("sat_flip", 32'(flip_count), 32'd255);
      check("sat_skip", 32'(skip_count), 32'd0);

      // random sequences with hold and stray load noise
      for (int s = 0; s < 8; s++) begin
         int n;
         load(16'($urandom));
         n = int'($urandom_range(5, 20));
         for (int i = 0; i <= n; i++) begin
            a = 2'($urandom_range(0, 3)); b = 2'($urandom_range(0, 3));
            c = 2'($urandom_range(0, 3)); d = 2'($urandom_range(0, 3));
            send(a, b, c, d, (i == n), 1'b1);
         end
         hold = 1'b0;
         wait_done(); wait_idle();
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/flip_ctrl.md
FLIP_CTRL -- requirements
Module: flip_ctrl

Interface
REQ-001 Parameter ROWS, default 4: matrix row count.
REQ-002 Parameter COLS, default 4: matrix column count.
REQ-003 Parameter DEPTH, default 4: command FIFO entries, power of two.
REQ-004 clk  input  1  single clock for all state.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 load_valid  input  1  initial matrix offered.
REQ-007 load_data  input  ROWS*COLS  initial matrix, bit index = c*ROWS + r.
REQ-008 load_ready  output  1  high only in IDLE.
REQ-009 cmd_valid  input  1  flip command offered.
REQ-010 cmd_r1, cmd_r2  input  2 each  rectangle row coordinates.
REQ-011 cmd_c1, cmd_c2  input  2 each  rectangle column coordinates.
REQ-012 cmd_last  input  1  final command of the sequence.
REQ-013 cmd_ready  output  1  command FIFO can accept.
REQ-014 hold  input  1  pauses FIFO pops while high.
REQ-015 m_out  output  ROWS*COLS  registered matrix.
REQ-016 busy  output  1  high in RUN.
REQ-017 done  output  1  one-cycle pulse at sequence end.
REQ-018 flip_count, skip_count  output  8 each  applied and skipped command counts.

Function
REQ-019 FSM states IDLE, RUN, DONE; IDLE->RUN on load handshake (load_valid & load_ready), m_out <= load_data at that edge, both counters cleared.
REQ-020 cmd_ready = !fifo_full in IDLE and RUN, 0 in DONE; fullness is registered, no same-cycle pop bypass.
REQ-021 Command pushes in IDLE are queued, not applied until RUN.
REQ-022 In RUN, when FIFO non-empty and hold low, exactly one command pops per cycle and is applied at that edge.
REQ-023 Apply: mask = OR of one-hot bits at (r1,c1),(r1,c2),(r2,c1),(r2,c2), index c*ROWS+r; m_out <= m_out XOR mask.
REQ-024 Degenerate command (r1==r2 or c1==c2): m_out unchanged, skip_count increments, flip_count does not.
REQ-025 Non-degenerate command: flip_count increments.
REQ-026 Counters saturate at 255, never wrap.
REQ-027 Latency: command accepted at edge N into empty FIFO in RUN with hold low is reflected in m_out after edge N+1.
REQ-028 Simultaneous push and pop: both occur, occupancy unchanged; FIFO pointers wrap modulo DEPTH.
REQ-029 Pop of a command with cmd_last set: RUN->DONE at that edge; done high for the following cycle only; DONE->IDLE unconditionally next edge.
REQ-030 Commands remaining in FIFO after the last command are discarded on DONE->IDLE.
REQ-031 load_valid outside IDLE ignored; m_out holds in IDLE and DONE.
REQ-032 busy = (state == RUN).

Reset
REQ-033 rst high: state IDLE, FIFO empty, m_out 0, flip_count 0, skip_count 0, done 0, busy 0, immediately and asynchronously.
REQ-034 rst mid-RUN aborts sequence with no done pulse; queued commands lost.

Structure
REQ-035 Shared package flip_pkg holds ROWS/COLS defaults, coordinate type (2-bit), command struct {r1,r2,c1,c2,last}, FSM state enum.
REQ-036 Sub-module rect_flip_mask: combinational, coordinates in, mask and degenerate flag out.
REQ-037 FIFO implemented inline in flip_ctrl.

Verification
REQ-038 Load 0x0000, cmd (r1=0,r2=1,c1=0,c2=1,last) -> m_out 0x0033, flip_count 1, done pulse one cycle, then IDLE.
REQ-039 Load 0x0000, same cmd twice, second last -> m_out 0x0000, flip_count 2.
REQ-040 Load 0xFFFF, cmd (r1=2,r2=2,c1=0,c2=3,last) -> m_out 0xFFFF, skip_count 1, flip_count 0.
REQ-041 RUN with hold high, push 4 cmds -> cmd_ready 0 after 4th; fifth offer not accepted; release hold -> 4 pops on 4 consecutive edges.
REQ-042 Assert rst during RUN with 2 queued -> outputs zero at once, no done, load_ready 1 after release.
REQ-043 300 non-degenerate cmds then last -> flip_count 255 (saturated).
